// File: rtl/i2c_multi_target.sv
// Oversampled I2C target answering NUM_ADDRS consecutive 7-bit addresses, with byte streaming ports.
// Optional macro I2C_CLK_STRETCH_EN: adds scl_o and stretches SCL instead of underrunning reads.
module i2c_multi_target #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] BASE_ADDR = 7'h22,
  parameter int NUM_ADDRS = 1,
  parameter int SYNC_STAGES = 2,
  localparam int CHAN_W = (NUM_ADDRS > 1) ? $clog2(NUM_ADDRS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
`ifdef I2C_CLK_STRETCH_EN
  output logic                      scl_o,
`endif
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic [CHAN_W-1:0]         wr_chan_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  input  logic                      rd_valid_i,
  output logic                      rd_ready_o,
  output logic                      rd_underrun_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      busy_o,
  output logic                      op_o
);

  localparam int DW    = I2C_DATA_WIDTH;
  localparam int RX_W  = (DW > I2C_ADDR_WIDTH + 1) ? DW : I2C_ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam logic [I2C_ADDR_WIDTH:0] NUM_A = (I2C_ADDR_WIDTH + 1)'(NUM_ADDRS);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_hist_reg, sda_hist_reg;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [RX_W-1:0]       rx_reg, rx_next;
  logic [DW-1:0]         tx_reg, tx_next;
  logic [DW-1:0]         wr_data_reg, wr_data_next;
  logic [CHAN_W-1:0]     chan_reg, chan_next;
  logic                  sda_reg, sda_next;
  logic                  busy_reg, busy_next;
  logic                  op_reg, op_next;
  logic                  nack_reg, nack_next;
  logic                  stretch_reg, stretch_next;
  logic                  wr_valid_reg, wr_valid_next;
  logic                  start_reg, start_next;
  logic                  stop_reg, stop_next;
  logic                  rd_ready, rd_underrun, load_req;
  logic [DW-1:0]         load_word;
  logic [I2C_ADDR_WIDTH-1:0] addr_diff;
  logic                  addr_match;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
      scl_hist_reg <= scl_s;
      sda_hist_reg <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_reg;
  assign scl_fall  = ~scl_s & scl_hist_reg;
  assign start_det = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
  assign stop_det  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

  // Unsigned wrap makes addresses below BASE_ADDR land far above NUM_ADDRS.
  assign addr_diff  = rx_reg[I2C_ADDR_WIDTH:1] - BASE_ADDR;
  assign addr_match = {1'b0, addr_diff} < NUM_A;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_reg       <= '0;
      tx_reg       <= '0;
      wr_data_reg  <= '0;
      chan_reg     <= '0;
      sda_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      op_reg       <= 1'b0;
      nack_reg     <= 1'b0;
      stretch_reg  <= 1'b0;
      wr_valid_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_reg       <= rx_next;
      tx_reg       <= tx_next;
      wr_data_reg  <= wr_data_next;
      chan_reg     <= chan_next;
      sda_reg      <= sda_next;
      busy_reg     <= busy_next;
      op_reg       <= op_next;
      nack_reg     <= nack_next;
      stretch_reg  <= stretch_next;
      wr_valid_reg <= wr_valid_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_next       = rx_reg;
    tx_next       = tx_reg;
    wr_data_next  = wr_data_reg;
    chan_next     = chan_reg;
    sda_next      = sda_reg;
    busy_next     = busy_reg;
    op_next       = op_reg;
    nack_next     = nack_reg;
    stretch_next  = stretch_reg;
    wr_valid_next = 1'b0;
    start_next    = 1'b0;
    stop_next     = 1'b0;
    rd_ready      = 1'b0;
    rd_underrun   = 1'b0;
    load_req      = stretch_reg;
`ifdef I2C_CLK_STRETCH_EN
    load_word     = rd_data_i;
`else
    load_word     = rd_valid_i ? rd_data_i : {DW{1'b1}};
`endif

    case (state_reg)
      ADDR: begin
        if (scl_rise) begin
          rx_next      = {rx_reg[RX_W-2:0], sda_s};
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end else if (scl_fall && bit_cnt_reg == CNT_W'(I2C_ADDR_WIDTH + 1)) begin
          bit_cnt_next = '0;
          if (addr_match) begin
            state_next = ADDR_ACK;
            sda_next   = 1'b0;
            op_next    = rx_reg[0];
            chan_next  = addr_diff[CHAN_W-1:0];
          end else begin
            state_next = WAIT_STOP;
          end
        end
      end
      ADDR_ACK: begin
        if (scl_fall) begin
          sda_next     = 1'b1;
          bit_cnt_next = '0;
          if (op_reg) load_req = 1'b1;
          else        state_next = WRITE;
        end
      end
      WRITE: begin
        if (scl_rise) begin
          rx_next      = {rx_reg[RX_W-2:0], sda_s};
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end else if (scl_fall && bit_cnt_reg == CNT_W'(DW)) begin
          wr_valid_next = 1'b1;
          wr_data_next  = rx_reg[DW-1:0];
          state_next    = WRITE_ACK;
          sda_next      = 1'b0;
          bit_cnt_next  = '0;
        end
      end
      WRITE_ACK: begin
        if (scl_fall) begin
          sda_next   = 1'b1;
          state_next = WRITE;
        end
      end
      READ: begin
        if (scl_fall && !stretch_reg) begin
          if (bit_cnt_reg == CNT_W'(DW)) begin
            sda_next   = 1'b1;
            state_next = READ_ACK;
          end else begin
            sda_next     = tx_reg[DW-1];
            tx_next      = tx_reg << 1;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      READ_ACK: begin
        if (scl_rise) begin
          nack_next = sda_s;
        end else if (scl_fall) begin
          if (nack_reg) state_next = WAIT_STOP;
          else          load_req = 1'b1;
        end
      end
      default: ;
    endcase

    // Byte load happens on the falling edge that opens the first data bit.
    if (load_req) begin
`ifdef I2C_CLK_STRETCH_EN
      stretch_next = !rd_valid_i;
      rd_ready     = rd_valid_i;
`else
      rd_ready     = 1'b1;
      rd_underrun  = !rd_valid_i;
`endif
      state_next = READ;
      if (rd_ready) begin
        sda_next     = load_word[DW-1];
        tx_next      = load_word << 1;
        bit_cnt_next = CNT_W'(1);
      end else begin
        sda_next     = 1'b1;
        bit_cnt_next = '0;
      end
    end

    if (start_det) begin
      state_next    = ADDR;
      bit_cnt_next  = '0;
      busy_next     = 1'b1;
      start_next    = 1'b1;
      sda_next      = 1'b1;
      stretch_next  = 1'b0;
      rd_ready      = 1'b0;
      rd_underrun   = 1'b0;
    end else if (stop_det) begin
      state_next    = IDLE;
      busy_next     = 1'b0;
      stop_next     = 1'b1;
      sda_next      = 1'b1;
      stretch_next  = 1'b0;
      rd_ready      = 1'b0;
      rd_underrun   = 1'b0;
    end
  end

  assign sda_o         = sda_reg;
`ifdef I2C_CLK_STRETCH_EN
  assign scl_o         = ~stretch_reg;
`endif
  assign wr_data_o     = wr_data_reg;
  assign wr_valid_o    = wr_valid_reg;
  assign wr_chan_o     = chan_reg;
  assign rd_ready_o    = rd_ready;
  assign rd_underrun_o = rd_underrun;
  assign start_o       = start_reg;
  assign stop_o        = stop_reg;
  assign busy_o        = busy_reg;
  assign op_o          = op_reg;

endmodule

// File: tb/tb_i2c_multi_target.sv
// Directed bench for i2c_multi_target: a bit-banged I2C master on a wired-AND bus, two-address target at 0x22.
module tb_i2c_multi_target;

  localparam int Q = 8;
  localparam int SCL_LIMIT = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, scl_m, sda_m, rd_valid;
  logic [7:0] rd_data;
  logic       sda_o, wr_valid, rd_ready, rd_underrun, start_p, stop_p, busy, op;
  logic [7:0] wr_data;
  logic [0:0] wr_chan;
  logic       scl_bus, sda_bus;

  assign sda_bus = sda_m & sda_o;
`ifdef I2C_CLK_STRETCH_EN
  logic scl_o;
  assign scl_bus = scl_m & scl_o;
`else
  assign scl_bus = scl_m;
`endif

  i2c_multi_target #(
    .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .BASE_ADDR(7'h22),
    .NUM_ADDRS(2), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus), .sda_o(sda_o),
`ifdef I2C_CLK_STRETCH_EN
    .scl_o(scl_o),
`endif
    .wr_data_o(wr_data), .wr_valid_o(wr_valid), .wr_chan_o(wr_chan),
    .rd_data_i(rd_data), .rd_valid_i(rd_valid), .rd_ready_o(rd_ready),
    .rd_underrun_o(rd_underrun), .start_o(start_p), .stop_o(stop_p),
    .busy_o(busy), .op_o(op)
  );

  int checks = 0;
  int failures = 0;

  // Event counters sampled away from the active edge.
  int start_cnt = 0, stop_cnt = 0, rdy_cnt = 0, unr_cnt = 0, sda_low_cnt = 0, scl_low_cnt = 0, wr_n = 0;
  logic [7:0] wr_log   [0:15];
  logic [0:0] chan_log [0:15];

  always @(negedge clk) begin
    if (start_p)     start_cnt   <= start_cnt + 1;
    if (stop_p)      stop_cnt    <= stop_cnt + 1;
    if (rd_ready)    rdy_cnt     <= rdy_cnt + 1;
    if (rd_underrun) unr_cnt     <= unr_cnt + 1;
    if (!sda_o)      sda_low_cnt <= sda_low_cnt + 1;
    if (!scl_bus && scl_m) scl_low_cnt <= scl_low_cnt + 1;
    if (wr_valid && wr_n < 16) begin
      wr_log[wr_n]   <= wr_data;
      chan_log[wr_n] <= wr_chan;
      wr_n           <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    while (scl_bus !== 1'b1 && n < SCL_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL scl_release_timeout observed=0 expected=1");
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] b1, b2;
    int s_start, s_stop, s_rdy, s_unr, s_low, s_wr;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rd_valid = 1'b0; rd_data = 8'h00;
    tick(5);
    check("rst_sda_o", {31'b0, sda_o}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_op", {31'b0, op}, 0);
    check("rst_wr_data", {24'b0, wr_data}, 0);
    check("rst_wr_chan", {31'b0, wr_chan}, 0);
    check("rst_strobes", {26'b0, wr_valid, start_p, stop_p, rd_ready, rd_underrun, 1'b0}, 0);
    rst_n = 1'b1;
    tick(10);

    // Write 0xA5, 0x3C to 0x22.
    s_start = start_cnt; s_stop = stop_cnt; s_wr = wr_n;
    i2c_start();
    check("wr_busy_after_start", {31'b0, busy}, 1);
    put_byte(8'h44, ack); check("wr_addr_ack", {31'b0, ack}, 0);
    check("wr_op", {31'b0, op}, 0);
    put_byte(8'hA5, ack); check("wr_byte0_ack", {31'b0, ack}, 0);
    put_byte(8'h3C, ack); check("wr_byte1_ack", {31'b0, ack}, 0);
    i2c_stop(); tick(10);
    check("wr_count", wr_n - s_wr, 2);
    check("wr_byte0", {24'b0, wr_log[s_wr]}, 32'hA5);
    check("wr_byte1", {24'b0, wr_log[s_wr + 1]}, 32'h3C);
    check("wr_chan0", {31'b0, chan_log[s_wr]}, 0);
    check("wr_start_pulses", start_cnt - s_start, 1);
    check("wr_stop_pulses", stop_cnt - s_stop, 1);
    check("wr_busy_after_stop", {31'b0, busy}, 0);

    // Read 0x5A, 0xC3 from 0x23 (channel 1), ACK then NACK.
    s_rdy = rdy_cnt; s_unr = unr_cnt;
    rd_data = 8'h5A; rd_valid = 1'b1;
    i2c_start();
    put_byte(8'h47, ack); check("rd_addr_ack", {31'b0, ack}, 0);
    check("rd_op", {31'b0, op}, 1);
    check("rd_chan", {31'b0, wr_chan}, 1);
    get_byte(b1);
    rd_data = 8'hC3;
    put_bit(1'b0);
    get_byte(b2);
    put_bit(1'b1);
    tick(4);
    check("rd_wait_stop_busy", {31'b0, busy}, 1);
    check("rd_wait_stop_sda", {31'b0, sda_o}, 1);
    i2c_stop(); tick(10);
    check("rd_byte0", {24'b0, b1}, 32'h5A);
    check("rd_byte1", {24'b0, b2}, 32'hC3);
    check("rd_ready_pulses", rdy_cnt - s_rdy, 2);
    check("rd_no_underrun", unr_cnt - s_unr, 0);
    check("rd_idle_busy", {31'b0, busy}, 0);

    // Unmatched 0x40 write; SDA must never be pulled.
    s_low = sda_low_cnt; s_wr = wr_n;
    i2c_start();
    put_byte(8'h80, ack); check("nm_addr_nack", {31'b0, ack}, 1);
    put_byte(8'h12, ack); check("nm_byte0_nack", {31'b0, ack}, 1);
    put_byte(8'h34, ack);
    check("nm_busy_before_stop", {31'b0, busy}, 1);
    i2c_stop(); tick(10);
    check("nm_sda_never_low", sda_low_cnt - s_low, 0);
    check("nm_no_wr_valid", wr_n - s_wr, 0);
    check("nm_busy_after_stop", {31'b0, busy}, 0);

    // Range edges: 0x24 is one past the top, 0x21 one below the base.
    i2c_start(); put_byte(8'h48, ack); check("edge_0x24_nack", {31'b0, ack}, 1); i2c_stop();
    i2c_start(); put_byte(8'h42, ack); check("edge_0x21_nack", {31'b0, ack}, 1); i2c_stop();
    tick(10);

    // Write 0x11, repeated START, read from 0x22.
    s_start = start_cnt; s_wr = wr_n;
    rd_data = 8'h96; rd_valid = 1'b1;
    i2c_start();
    put_byte(8'h44, ack);
    put_byte(8'h11, ack); check("rs_write_ack", {31'b0, ack}, 0);
    check("rs_op_write", {31'b0, op}, 0);
    i2c_start();
    put_byte(8'h45, ack); check("rs_read_addr_ack", {31'b0, ack}, 0);
    check("rs_op_read", {31'b0, op}, 1);
    check("rs_chan", {31'b0, wr_chan}, 0);
    get_byte(b1);
    put_bit(1'b1);
    i2c_stop(); tick(10);
    check("rs_wr_byte", {24'b0, wr_log[s_wr]}, 32'h11);
    check("rs_start_pulses", start_cnt - s_start, 2);
    check("rs_rd_byte", {24'b0, b1}, 32'h96);

    // Read with no data available.
    s_rdy = rdy_cnt; s_unr = unr_cnt;
    rd_valid = 1'b0; rd_data = 8'h00;
`ifdef I2C_CLK_STRETCH_EN
    fork
      begin
        tick(300);
        rd_data = 8'h77;
        rd_valid = 1'b1;
      end
    join_none
`endif
    i2c_start();
    put_byte(8'h45, ack); check("ur_addr_ack", {31'b0, ack}, 0);
    get_byte(b1);
    put_bit(1'b1);
    i2c_stop(); tick(10);
`ifdef I2C_CLK_STRETCH_EN
    check("st_byte", {24'b0, b1}, 32'h77);
    check("st_no_underrun", unr_cnt - s_unr, 0);
    check("st_scl_held", {31'b0, (scl_low_cnt > 200)}, 1);
`else
    check("ur_byte", {24'b0, b1}, 32'hFF);
    check("ur_pulses", unr_cnt - s_unr, 1);
`endif
    check("ur_ready_pulses", rdy_cnt - s_rdy, 1);
    rd_valid = 1'b0;

    // Reset inside the address ACK slot of a write.
    s_wr = wr_n;
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(b2[0] ^ b2[0] ^ ((8'h44 >> i) & 8'h01) != 0);
    check("rr_ack_driven", {31'b0, sda_o}, 0);
    rst_n = 1'b0;
    tick(1);
    check("rr_sda_released", {31'b0, sda_o}, 1);
    check("rr_busy_cleared", {31'b0, busy}, 0);
    rst_n = 1'b1;
    s_low = sda_low_cnt;
    get_bit(ack); check("rr_slot_released", {31'b0, ack}, 1);
    put_byte(8'h55, ack);
    i2c_stop(); tick(10);
    check("rr_sda_never_low", sda_low_cnt - s_low, 0);
    check("rr_no_wr_valid", wr_n - s_wr, 0);
    i2c_start();
    put_byte(8'h44, ack); check("rr_next_addr_ack", {31'b0, ack}, 0);
    put_byte(8'h66, ack); check("rr_next_byte_ack", {31'b0, ack}, 0);
    i2c_stop(); tick(10);
    check("rr_next_wr_byte", {24'b0, wr_log[s_wr]}, 32'h66);
    check("rr_next_count", wr_n - s_wr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_multi_target.md
Name: i2c_multi_target

Overview:
- Synthesisable, clock-oversampled I2C target; the RTL successor to the behavioural I2C slave model.
- Responds to a contiguous range of NUM_ADDRS 7-bit addresses (one channel per address) and reports the matched channel index.
- Streams received write bytes out and accepts read bytes in over a valid/ready port.
- Sits between the open-drain pads and a register-file or test-responder back end.

Parameters:
I2C_ADDR_WIDTH, 7, target address width (only 7 supported)
I2C_DATA_WIDTH, 8, bits per data phase before each ACK slot
BASE_ADDR, 7'h22, lowest matched address
NUM_ADDRS, 1, matched range BASE_ADDR..BASE_ADDR+NUM_ADDRS-1 (1..16)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  synchronous active-low reset
scl_i  in  1  SCL pad input
sda_i  in  1  SDA pad input
sda_o  out  1  0 = pull SDA low, 1 = release
wr_data_o  out  I2C_DATA_WIDTH  received write byte
wr_valid_o  out  1  one-cycle strobe, wr_data_o/wr_chan_o valid
wr_chan_o  out  max(1,$clog2(NUM_ADDRS))  matched channel
rd_data_i  in  I2C_DATA_WIDTH  byte to transmit
rd_valid_i  in  1  rd_data_i available
rd_ready_o  out  1  one-cycle load strobe; transfer when rd_valid_i && rd_ready_o
rd_underrun_o  out  1  one-cycle pulse, read byte needed but rd_valid_i low
start_o  out  1  pulse on START or repeated START
stop_o  out  1  pulse on STOP
busy_o  out  1  high from START to STOP
op_o  out  1  0 = write, 1 = read; valid after the address phase

Behaviour:
- Reset (rst_n_i low at posedge clk_i): state IDLE; sda_o=1; all strobes 0; busy_o=0; op_o=0; wr_data_o=0; wr_chan_o=0; synchroniser flops set to 1. Reset mid-transfer releases SDA on the next clock.
- SCL/SDA pass through SYNC_STAGES flops plus one history flop. Edges and conditions are detected on synchronised values only.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- SDA is sampled on the SCL rising edge. sda_o changes only in the cycle after a detected SCL falling edge (SYNC_STAGES+1 clocks after the pad edge). The bus SCL low time must be >= SYNC_STAGES+3 clocks.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- START in any state: go to ADDR, clear the bit counter, assert busy_o, pulse start_o.
- STOP in any state: go to IDLE, sda_o=1, busy_o=0, pulse stop_o.
- ADDR: shift 8 bits, MSB first; bit 0 is R/W.
  - Match = addr - BASE_ADDR < NUM_ADDRS (unsigned); latch wr_chan_o and op_o.
  - Matched: go to ADDR_ACK and drive sda_o=0 from the 8th falling SCL edge to the 9th.
  - Unmatched: go to WAIT_STOP and keep SDA released.
- ADDR_ACK, write (op_o=0): go to WRITE.
  - After I2C_DATA_WIDTH bits: pulse wr_valid_o with the byte, go to WRITE_ACK, drive ACK for one SCL period, return to WRITE.
  - No back-pressure.
- ADDR_ACK, read (op_o=1): at the 9th falling edge, pulse rd_ready_o.
  - If rd_valid_i: load rd_data_i.
  - Else: load all-ones and pulse rd_underrun_o.
  - Drive the MSB, then shift one bit per falling edge.
  - After the last bit: release SDA and go to READ_ACK.
  - Sample master ACK at rising edge. ACK (0): next falling edge repeats the load and goes to READ. NACK (1): WAIT_STOP.
- WAIT_STOP: SDA released; leaves only on START or STOP.
- A START and a STOP condition are mutually exclusive in one cycle. START during any ACK slot aborts the slot and releases SDA.

Optional Feature:
I2C_CLK_STRETCH_EN
- Defined: adds output scl_o (1 bit; 0 = hold SCL low, reset 1).
  - In READ load cycles with rd_valid_i low: hold SCL low instead of underrunning, load when rd_valid_i rises, release SCL the next cycle.
  - rd_underrun_o is tied to 0.
- Undefined: no scl_o port; all-ones substitution and underrun pulse as above.

Test Plan:
- NUM_ADDRS=1, write to 0x22, bytes 0xA5, 0x3C, STOP -> ACK low on 3 slots; wr_valid_o twice with 0xA5 then 0x3C; wr_chan_o=0; start_o and stop_o one pulse each.
- NUM_ADDRS=2, read from 0x23, rd_data_i 0x5A then 0xC3, master ACKs then NACKs -> bus sees 0x5A, 0xC3; wr_chan_o=1; op_o=1; two rd_ready_o pulses; state WAIT_STOP then IDLE.
- Address 0x40 write with 2 bytes -> SDA never low; no wr_valid_o; busy_o drops on STOP.
- Write 0x22 byte 0x11, repeated START, read 0x22 -> wr_valid_o with 0x11; second start_o pulse; op_o switches to 1; read byte driven correctly.
- Read with rd_valid_i low -> bus sees 0xFF and rd_underrun_o pulses. With I2C_CLK_STRETCH_EN: SCL held low until rd_valid_i goes high with 0x77, then 0x77 is sent.
- Assert rst_n_i during the ACK slot of a write -> sda_o=1 next clock, busy_o=0, no wr_valid_o; the next transaction completes normally.
